// File: rtl/pwm_gen_array_if.sv
// Config/modulation bus and PWM output bundle for pwm_gen_array (master = bus driver, slave = generator).
// MASK is present only when PWM_GEN_ARRAY_OUTPUT_MASK_EN is defined.
interface pwm_gen_array_if #(
  parameter int WIDTH  = 13,
  parameter int NUM_CH = 249,
  parameter int ADDR_W = 8
);
  logic              SYNC;
  logic [WIDTH-1:0]  CYCLE;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [WIDTH-1:0]  WR_DUTY;
  logic [WIDTH-1:0]  WR_PHASE;
  logic              COMMIT;
  logic [WIDTH-1:0]  TIME_CNT;
  logic              UPDATE;
  logic [NUM_CH-1:0] PWM_OUT;
`ifdef PWM_GEN_ARRAY_OUTPUT_MASK_EN
  logic [NUM_CH-1:0] MASK;
`endif

  modport master (
`ifdef PWM_GEN_ARRAY_OUTPUT_MASK_EN
    output MASK,
`endif
    output SYNC, CYCLE, WR_EN, WR_ADDR, WR_DUTY, WR_PHASE, COMMIT,
    input  TIME_CNT, UPDATE, PWM_OUT
  );

  modport slave (
`ifdef PWM_GEN_ARRAY_OUTPUT_MASK_EN
    input  MASK,
`endif
    input  SYNC, CYCLE, WR_EN, WR_ADDR, WR_DUTY, WR_PHASE, COMMIT,
    output TIME_CNT, UPDATE, PWM_OUT
  );
endinterface

// File: rtl/pwm_gen_array.sv
// NUM_CH-channel PWM with staged duty/phase committed atomically at period boundaries; writes land 2 clks
// after WR_EN, PWM_OUT lags TIME_CNT by 1 clk, no backpressure (1 write/clk). Optional MASK: PWM_GEN_ARRAY_OUTPUT_MASK_EN.
module pwm_gen_array #(
  parameter int WIDTH  = 13,
  parameter int NUM_CH = 249,
  parameter int ADDR_W = 8
) (
  input logic            CLK,
  input logic            RST_N,
  pwm_gen_array_if.slave bus
);
  localparam logic [WIDTH-1:0]  C_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0]  C_TWO = WIDTH'(2);
  localparam logic [ADDR_W:0]   C_NCH = (ADDR_W+1)'(NUM_CH);

  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_cycle;
  logic              r_pend;
  logic              r_update;
  logic [NUM_CH-1:0] r_pwm;

  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [WIDTH-1:0]  r_s1_duty;
  logic [WIDTH-1:0]  r_s1_phase;

  logic [NUM_CH-1:0][WIDTH-1:0] r_stg_left, r_stg_right, r_act_left, r_act_right;
  logic [NUM_CH-1:0]            r_stg_over, r_act_over;

  logic              w_run, w_last, w_bnd, w_load;
  logic [WIDTH-1:0]  w_ph_mod;
  logic [WIDTH:0]    w_sum, w_diff;
  logic [WIDTH-1:0]  w_e_left, w_e_right;
  logic              w_e_over;
  logic [NUM_CH-1:0] w_pwm, w_chan_en;

  // Periods shorter than 2 clocks park the counter and keep re-sampling CYCLE.
  assign w_run  = (r_cycle >= C_TWO);
  assign w_last = w_run && (r_cnt == r_cycle - C_ONE);
  assign w_bnd  = w_last || bus.SYNC;
  assign w_load = w_bnd && (r_pend || bus.COMMIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt    <= '0;
      r_cycle  <= '0;
      r_pend   <= 1'b0;
      r_update <= 1'b0;
    end else begin
      if (!w_run || w_last) r_cycle <= bus.CYCLE;
      if (bus.SYNC || !w_run || w_last) r_cnt <= '0;
      else                              r_cnt <= r_cnt + C_ONE;
      r_pend   <= w_load ? 1'b0 : (r_pend | bus.COMMIT);
      r_update <= w_load;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_vld   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_duty  <= '0;
      r_s1_phase <= '0;
    end else begin
      r_s1_vld   <= bus.WR_EN && ({1'b0, bus.WR_ADDR} < C_NCH);
      r_s1_addr  <= bus.WR_ADDR;
      r_s1_duty  <= bus.WR_DUTY;
      r_s1_phase <= bus.WR_PHASE;
    end
  end

  // The zero guard only keeps the modulo defined; the edge logic never uses it when cycle is 0.
  assign w_ph_mod = (r_cycle == '0) ? r_s1_phase : (r_s1_phase % r_cycle);
  assign w_sum    = {1'b0, w_ph_mod} + {1'b0, r_s1_duty};
  assign w_diff   = w_sum - {1'b0, r_cycle};

  always_comb begin
    w_e_left  = '0;
    w_e_right = '0;
    w_e_over  = 1'b0;
    if (r_s1_duty != '0) begin
      if (r_s1_duty >= r_cycle) begin
        w_e_over = 1'b1;
      end else begin
        w_e_left = w_ph_mod;
        if (w_sum < {1'b0, r_cycle}) begin
          w_e_right = w_sum[WIDTH-1:0];
        end else begin
          w_e_right = w_diff[WIDTH-1:0];
          w_e_over  = 1'b1;
        end
      end
    end
  end

  // Active copies read staging before this clock's stage-2 write, so that write misses this commit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stg_left  <= '0;
      r_stg_right <= '0;
      r_stg_over  <= '0;
      r_act_left  <= '0;
      r_act_right <= '0;
      r_act_over  <= '0;
    end else begin
      if (r_s1_vld) begin
        r_stg_left[r_s1_addr]  <= w_e_left;
        r_stg_right[r_s1_addr] <= w_e_right;
        r_stg_over[r_s1_addr]  <= w_e_over;
      end
      if (w_load) begin
        r_act_left  <= r_stg_left;
        r_act_right <= r_stg_right;
        r_act_over  <= r_stg_over;
      end
    end
  end

`ifdef PWM_GEN_ARRAY_OUTPUT_MASK_EN
  logic [NUM_CH-1:0] r_mask;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     r_mask <= '1;
    else if (w_bnd) r_mask <= bus.MASK;
  end

  assign w_chan_en = r_mask;
`else
  assign w_chan_en = '1;
`endif

  always_comb begin
    w_pwm = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_act_over[i]) w_pwm[i] = (r_cnt < r_act_right[i]) | (r_act_left[i] <= r_cnt);
      else               w_pwm[i] = (r_act_left[i] <= r_cnt) & (r_cnt < r_act_right[i]);
    end
    w_pwm = w_pwm & w_chan_en & {NUM_CH{w_run}};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_pwm <= '0;
    else        r_pwm <= w_pwm;
  end

  assign bus.TIME_CNT = r_cnt;
  assign bus.UPDATE   = r_update;
  assign bus.PWM_OUT  = r_pwm;
endmodule

// File: tb/tb_pwm_gen_array.sv
// Directed and randomized bench for pwm_gen_array, compared every cycle against a period/phase reference model.
module tb_pwm_gen_array;
  localparam int WIDTH  = 13;
  localparam int NUM_CH = 249;
  localparam int ADDR_W = 8;
  typedef logic [NUM_CH-1:0] vec_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  pwm_gen_array_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  pwm_gen_array #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: per channel the period seen at write time, phase within it, and duty.
  int   m_t, m_cyc;
  bit   m_pend, m_upd;
  vec_t m_pwm, m_mask;
  int   stg_cw[NUM_CH], stg_p[NUM_CH], stg_d[NUM_CH];
  int   act_cw[NUM_CH], act_p[NUM_CH], act_d[NUM_CH];
  bit   s1_v;
  int   s1_a, s1_d, s1_p;

  function automatic bit ch_high(int cw, int p, int d, int t);
    if (d == 0) return 1'b0;
    if (d >= cw) return 1'b1;
    if (t < cw) return (((t - p + cw) % cw) < d);
    return ((p + d) >= cw);
  endfunction

  task automatic model_step();
    bit   b, ld;
    vec_t np;
    int   nt;
    if (!RST_N) begin
      m_t = 0; m_cyc = 0; m_pend = 1'b0; m_upd = 1'b0; m_pwm = '0; m_mask = '1; s1_v = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        stg_cw[i] = 0; stg_p[i] = 0; stg_d[i] = 0;
        act_cw[i] = 0; act_p[i] = 0; act_d[i] = 0;
      end
      return;
    end
    b = ((m_cyc >= 2) && (m_t == m_cyc - 1)) || bus.SYNC;
    np = '0;
    for (int i = 0; i < NUM_CH; i++)
      np[i] = (m_cyc >= 2) && m_mask[i] && ch_high(act_cw[i], act_p[i], act_d[i], m_t);
    ld = b && (m_pend || bus.COMMIT);
    m_pwm  = np;
    m_upd  = ld;
    m_pend = !ld && (m_pend || bus.COMMIT);
    if (ld) begin
      for (int i = 0; i < NUM_CH; i++) begin
        act_cw[i] = stg_cw[i]; act_p[i] = stg_p[i]; act_d[i] = stg_d[i];
      end
    end
    if (s1_v) begin
      stg_cw[s1_a] = m_cyc;
      stg_d[s1_a]  = s1_d;
      stg_p[s1_a]  = (m_cyc == 0) ? s1_p : (s1_p % m_cyc);
    end
    s1_v = bus.WR_EN && (int'(bus.WR_ADDR) < NUM_CH);
    s1_a = int'(bus.WR_ADDR);
    s1_d = int'(bus.WR_DUTY);
    s1_p = int'(bus.WR_PHASE);
`ifdef PWM_GEN_ARRAY_OUTPUT_MASK_EN
    if (b) m_mask = bus.MASK;
`endif
    nt = (bus.SYNC || (m_cyc < 2) || (m_t == m_cyc - 1)) ? 0 : m_t + 1;
    if ((m_cyc < 2) || (m_t == m_cyc - 1)) m_cyc = int'(bus.CYCLE);
    m_t = nt;
  endtask

  task automatic check(string tag, vec_t obs, vec_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check("time_cnt", vec_t'(bus.TIME_CNT), vec_t'(m_t));
    check("update", vec_t'(bus.UPDATE), vec_t'(m_upd));
    check("pwm_out", bus.PWM_OUT, m_pwm);
  endtask

  task automatic run(int n);
    repeat (n) cyc1();
  endtask

  task automatic wait_t(int v, int budget);
    int k = 0;
    while ((int'(bus.TIME_CNT) != v) && (k < budget)) begin
      cyc1();
      k++;
    end
    check("wait_time_cnt", vec_t'(bus.TIME_CNT), vec_t'(v));
  endtask

  task automatic wait_upd(int budget);
    int k = 0;
    do begin
      cyc1();
      k++;
    end while (!bus.UPDATE && (k < budget));
    check("wait_update", vec_t'(bus.UPDATE), vec_t'(1));
  endtask

  task automatic wr(int a, int d, int p);
    bus.WR_EN    = 1'b1;
    bus.WR_ADDR  = ADDR_W'(a);
    bus.WR_DUTY  = WIDTH'(d);
    bus.WR_PHASE = WIDTH'(p);
    cyc1();
    bus.WR_EN = 1'b0;
  endtask

  task automatic commit();
    bus.COMMIT = 1'b1;
    cyc1();
    bus.COMMIT = 1'b0;
  endtask

  initial begin
    bus.SYNC = 1'b0; bus.CYCLE = WIDTH'(5000); bus.WR_EN = 1'b0; bus.WR_ADDR = '0;
    bus.WR_DUTY = '0; bus.WR_PHASE = '0; bus.COMMIT = 1'b0;
`ifdef PWM_GEN_ARRAY_OUTPUT_MASK_EN
    bus.MASK = '1;
`endif
    run(3);
    check("reset_pwm_zero", bus.PWM_OUT, vec_t'(0));
    RST_N = 1'b1;
    run(3);

    // 50% duty on ch0, wrapped pulse on ch3
    wr(0, 2500, 0);
    wr(3, 1000, 4500);
    commit();
    wait_upd(6000);
    cyc1();
    check("update_single_pulse", vec_t'(bus.UPDATE), vec_t'(0));
    wait_t(10, 100);
    check("ch0_high_t9", vec_t'(bus.PWM_OUT[0]), vec_t'(1));
    check("ch3_high_t9", vec_t'(bus.PWM_OUT[3]), vec_t'(1));
    wait_t(2501, 3000);
    check("ch0_low_t2500", vec_t'(bus.PWM_OUT[0]), vec_t'(0));
    wait_t(4500, 3000);
    check("ch3_low_t4499", vec_t'(bus.PWM_OUT[3]), vec_t'(0));
    cyc1();
    check("ch3_high_t4500", vec_t'(bus.PWM_OUT[3]), vec_t'(1));

    // Extremes at CYCLE=100
    bus.CYCLE = WIDTH'(100);
    wait_t(4999, 6000);
    cyc1();
    wr(1, 0, 7);
    wr(2, 100, 3);
    wr(5, 4000, 0);
    commit();
    wait_upd(300);
    run(2);
    check("ch1_const_low", vec_t'(bus.PWM_OUT[1]), vec_t'(0));
    check("ch2_const_high", vec_t'(bus.PWM_OUT[2]), vec_t'(1));
    check("ch5_const_high", vec_t'(bus.PWM_OUT[5]), vec_t'(1));
    run(250);

    // Atomic update of ch0..9 written across several periods
    for (int ch = 0; ch < 10; ch++) begin
      if (ch == 7) wr(7, 0, 0);
      else         wr(ch, $urandom_range(1, 130), $urandom_range(0, 200));
      run($urandom_range(0, 40));
    end
    wait_t(50, 200);
    commit();
    wait_upd(200);
    run(19);
    check("ch7_off_after_commit", vec_t'(bus.PWM_OUT[7]), vec_t'(0));
    // Write whose stage 2 coincides with the boundary clock
    wait_t(98, 200);
    bus.WR_EN = 1'b1; bus.WR_ADDR = ADDR_W'(7); bus.WR_DUTY = WIDTH'(50); bus.WR_PHASE = WIDTH'(10);
    bus.COMMIT = 1'b1;
    cyc1();
    bus.WR_EN = 1'b0; bus.COMMIT = 1'b0;
    wait_upd(5);
    run(19);
    check("ch7_boundary_write_excluded", vec_t'(bus.PWM_OUT[7]), vec_t'(0));
    commit();
    wait_upd(200);
    run(19);
    check("ch7_second_commit", vec_t'(bus.PWM_OUT[7]), vec_t'(1));

    // SYNC with pending commit, CYCLE change deferred to next wrap
    bus.CYCLE = WIDTH'(5000);
    wait_t(99, 200);
    cyc1();
    wr(0, 300, 1300);
    commit();
    bus.CYCLE = WIDTH'(4000);
    wait_t(1234, 6000);
    bus.SYNC = 1'b1;
    cyc1();
    bus.SYNC = 1'b0;
    check("sync_restart", vec_t'(bus.TIME_CNT), vec_t'(0));
    check("sync_update", vec_t'(bus.UPDATE), vec_t'(1));
    wait_t(1300, 2000);
    check("ch0_low_t1299", vec_t'(bus.PWM_OUT[0]), vec_t'(0));
    cyc1();
    check("ch0_high_t1300", vec_t'(bus.PWM_OUT[0]), vec_t'(1));
    wait_t(4999, 6000);
    cyc1();
    wait_t(3999, 5000);
    cyc1();
    check("cycle_4000_wrap", vec_t'(bus.TIME_CNT), vec_t'(0));

    // Random traffic, including out-of-range addresses and CYCLE changes
    for (int n = 0; n < 12000; n++) begin
      if ((n % 3000) == 0) bus.CYCLE = WIDTH'($urandom_range(50, 4000));
      bus.WR_EN    = ($urandom_range(0, 7) == 0);
      bus.WR_ADDR  = ADDR_W'($urandom_range(0, 255));
      bus.WR_DUTY  = WIDTH'($urandom_range(0, 4500));
      bus.WR_PHASE = WIDTH'($urandom_range(0, 8191));
      bus.COMMIT   = ($urandom_range(0, 399) == 0);
      bus.SYNC     = ($urandom_range(0, 2999) == 0);
      cyc1();
    end
    bus.WR_EN = 1'b0; bus.COMMIT = 1'b0; bus.SYNC = 1'b0;
    bus.CYCLE = WIDTH'(1000);
    cyc1();
    wait_t(0, 5000);

`ifdef PWM_GEN_ARRAY_OUTPUT_MASK_EN
    wr(4, 8000, 0);
    commit();
    wait_upd(2000);
    wait_t(100, 1000);
    bus.MASK = '1;
    bus.MASK[4] = 1'b0;
    wait_t(200, 1000);
    check("mask_holds_mid_period", vec_t'(bus.PWM_OUT[4]), vec_t'(1));
    wait_t(1, 1000);
    check("mask_low_after_boundary", vec_t'(bus.PWM_OUT[4]), vec_t'(0));
    bus.MASK = '1;
    wait_t(500, 1000);
    check("unmask_waits_boundary", vec_t'(bus.PWM_OUT[4]), vec_t'(0));
    wait_t(2, 1000);
    check("unmask_resumes", vec_t'(bus.PWM_OUT[4]), vec_t'(1));
`endif

    // Reset mid-operation with a write and commit in flight
    bus.WR_EN = 1'b1; bus.WR_ADDR = ADDR_W'(9); bus.WR_DUTY = WIDTH'(500); bus.WR_PHASE = WIDTH'(0);
    bus.COMMIT = 1'b1;
    cyc1();
    RST_N = 1'b0;
    #1;
    check("async_reset_time", vec_t'(bus.TIME_CNT), vec_t'(0));
    check("async_reset_pwm", bus.PWM_OUT, vec_t'(0));
    bus.WR_EN = 1'b0; bus.COMMIT = 1'b0;
    cyc1();
    RST_N = 1'b1;
    run(1100);
    check("post_reset_all_off", bus.PWM_OUT, vec_t'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_gen_array.md
Name: pwm_gen_array

Overview:
Multi-channel successor to the single-channel PWM generator. It owns its own period counter and per-channel duty/phase staging registers, with edge computation in a one-stage pipeline. Staging registers are committed atomically to all channels at a period boundary. It sits between the modulation/config bus and the transducer output pins and drives NUM_CH PWM lines with glitch-free, period-aligned updates.

Parameters:
WIDTH, 13, bit width of counter, CYCLE, duty, phase and edge registers
NUM_CH, 249, number of PWM channels
ADDR_W, 8, write-address width; must satisfy 2**ADDR_W >= NUM_CH

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
SYNC  in  1  single-cycle pulse; restarts period counter at 0
CYCLE  in  WIDTH  period length in clocks; sampled at each period boundary
WR_EN  in  1  staging write strobe
WR_ADDR  in  ADDR_W  channel index
WR_DUTY  in  WIDTH  high time in clocks
WR_PHASE  in  WIDTH  rising-edge position in clocks
COMMIT  in  1  single-cycle pulse; arms atomic staging-to-active transfer
TIME_CNT  out  WIDTH  current period counter value
UPDATE  out  1  one-cycle pulse when a commit takes effect
PWM_OUT  out  NUM_CH  registered PWM outputs

Behaviour:
- Reset (RST_N low, asynchronous): counter=0, cycle_q=0, pending=0, UPDATE=0, PWM_OUT=0. All staging/active left=0, right=0, over=0 (channel off).
- Counter t: cycle_q loads CYCLE when t==cycle_q-1 and on the first clock after reset.
- Counter t: increments each clock and wraps to 0 at cycle_q-1.
- Counter t: SYNC forces t=0 on the next clock, overriding wrap.
- Counter t: if cycle_q<2, t holds 0 and all PWM_OUT=0.
- TIME_CNT = t, combinational from the register.
- Boundary event B: t==cycle_q-1 and cycle_q>=2, or SYNC asserted. SYNC counts as a boundary so commits land aligned to the restarted period.
- Write pipeline stage 1 (the WR_EN cycle): latch addr, duty, phase. WR_ADDR>=NUM_CH is ignored.
- Write pipeline stage 2: compute edges into staging[addr], using WIDTH+1-bit sums and phase taken mod cycle_q.
- Edge rule, duty==0: left=0, right=0, over=0 (constant low).
- Edge rule, duty>=cycle_q: left=0, right=0, over=1 (constant high).
- Edge rule, otherwise: left=phase, s=phase+duty. If s<cycle_q then right=s, over=0; else right=s-cycle_q, over=1.
- Staging write lands 2 clocks after WR_EN. Back-to-back writes are sustained at 1/clock. Writes to the same address: last write wins.
- Commit: COMMIT sets pending. At B with pending=1, all active regs load from staging in one clock, pending clears, and UPDATE pulses in the following cycle.
- COMMIT coincident with B takes effect at that B.
- A write whose stage 2 coincides with B is not included in that commit.
- COMMIT while already pending has no extra effect.
- Output: pwm[i] <= over ? (t<right)|(left<=t) : (left<=t)&(t<right). Output latency is 1 clock from TIME_CNT.
- The over=1, left=0, right=0 case yields constant high, as required.
- Reset mid-operation: pending and pipeline are discarded; writes in flight are lost.

Optional Feature:
PWM_GEN_ARRAY_OUTPUT_MASK_EN
- Defined: adds input MASK [NUM_CH-1:0]. MASK is sampled into mask_q at each B (reset value all-ones = enabled). PWM_OUT[i] = pwm[i] & mask_q[i]. Masked channels go low at the boundary with no runt pulse.
- Undefined: no MASK port; PWM_OUT = pwm.

Test Plan:
- Reset, CYCLE=5000, write ch0 duty=2500 phase=0, COMMIT -> after next boundary PWM_OUT[0] high for t=0..2499, low for 2500..4999, delayed 1 clk vs TIME_CNT; UPDATE pulses once.
- Wrap case, CYCLE=5000, ch3 duty=1000 phase=4500 -> over=1, right=500; high for t in [4500,4999]∪[0,499].
- Extremes, CYCLE=100: ch1 duty=0 -> constant low; ch2 duty=100 and ch5 duty=4000 -> constant high; all other channels unchanged.
- Atomicity: write ch0..ch9 over several periods, COMMIT mid-period -> all 10 channels change in the same clock at the boundary. A write with stage 2 on the boundary clock appears only after a second COMMIT.
- SYNC at t=1234 with pending commit -> TIME_CNT=0 next clock, new edges active immediately, UPDATE=1 one clock later. CYCLE change from 5000 to 4000 applies only from the next boundary.
- Macro defined: MASK[4]=0 asserted mid-period -> PWM_OUT[4] stays as is until the boundary, then 0. Reassert -> resumes at the following boundary.
